// File: rtl/proc_param_if.sv
// Processor bus-side signals: instruction/immediate input, run request,
// completion strobe, shared bus value and zero flag.
interface proc_param_if #(parameter int DW = 16);
   logic [DW-1:0] DIN;
   logic          Run;
   logic          Done;
   logic [DW-1:0] BusWires;
   logic          Zero;

   modport master (output DIN, output Run, input Done, input BusWires, input Zero);
   modport slave  (input DIN, input Run, output Done, output BusWires, output Zero);
endinterface

// File: rtl/proc_param.sv
// Parametrised multicycle bus processor: mv/mvi/add/sub/and/or/mvnz over a
// one-hot bus shared by DIN, G and the register file.
module proc_param #(
   parameter int DW = 16,
   parameter int RB = 3
) (
   input logic         Clock,
   input logic         Reset,
   proc_param_if.slave io
);
   localparam int IRW  = 3 + 2*RB;
   localparam int NREG = 2**RB;

   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
   typedef enum logic [2:0] {
      OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MVNZ, OP_RSV
   } op_t;

   step_t                    step, step_nx;
   logic [IRW-1:0]           ir;
   op_t                      op;
   logic [RB-1:0]            rx, ry;
   logic [NREG-1:0][DW-1:0]  r;
   logic [DW-1:0]            a, g, alu, bus_val;
   logic                     zero;

   logic                     ir_in, a_in, g_in, din_out, g_out, done;
   logic [NREG-1:0]          r_in, r_out;

   assign op = op_t'(ir[IRW-1 -: 3]);
   assign rx = ir[2*RB-1 -: RB];
   assign ry = ir[RB-1:0];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) step <= T0;
      else       step <= step_nx;
   end

   // Control: every select line defaults low, so T0 leaves the bus at zero.
   always_comb begin
      step_nx = step;
      ir_in   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      din_out = 1'b0;
      g_out   = 1'b0;
      done    = 1'b0;
      r_in    = '0;
      r_out   = '0;
      case (step)
         T0: if (io.Run) begin
            ir_in   = 1'b1;
            step_nx = T1;
         end
         T1: begin
            case (op)
               OP_MV: begin
                  r_out[ry] = 1'b1;
                  r_in[rx]  = 1'b1;
                  done      = 1'b1;
               end
               OP_MVI: begin
                  din_out  = 1'b1;
                  r_in[rx] = 1'b1;
                  done     = 1'b1;
               end
               OP_MVNZ: begin
                  r_out[ry] = 1'b1;
                  r_in[rx]  = ~zero;
                  done      = 1'b1;
               end
               OP_RSV: done = 1'b1;
               default: begin
                  r_out[rx] = 1'b1;
                  a_in      = 1'b1;
                  step_nx   = T2;
               end
            endcase
         end
         T2: begin
            r_out[ry] = 1'b1;
            g_in      = 1'b1;
            step_nx   = T3;
         end
         T3: begin
            g_out    = 1'b1;
            r_in[rx] = 1'b1;
            done     = 1'b1;
         end
         default: step_nx = T0;
      endcase
      if (done) step_nx = T0;
   end

   // Bus is an AND-OR of one-hot selects; nothing selected yields zero.
   always_comb begin
      bus_val = '0;
      if (din_out) bus_val = bus_val | io.DIN;
      if (g_out)   bus_val = bus_val | g;
      for (int i = 0; i < NREG; i++)
         if (r_out[i]) bus_val = bus_val | r[i];
   end

   always_comb begin
      case (op)
         OP_ADD:  alu = a + bus_val;
         OP_SUB:  alu = a - bus_val;
         OP_AND:  alu = a & bus_val;
         default: alu = a | bus_val;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ir   <= '0;
         a    <= '0;
         g    <= '0;
         r    <= '0;
         zero <= 1'b1;
      end else begin
         if (ir_in) ir <= io.DIN[IRW-1:0];
         if (a_in)  a  <= bus_val;
         if (g_in) begin
            g    <= alu;
            zero <= (alu == '0);
         end
         for (int i = 0; i < NREG; i++)
            if (r_in[i]) r[i] <= bus_val;
      end
   end

   assign io.Done     = done;
   assign io.BusWires = bus_val;
   assign io.Zero     = zero;
endmodule
